// File: rtl/mips_multicycle_ctrl_if.sv
// Memory port handshake shared by instruction fetch and load/store.
//   mem_req   : controller requests an access this cycle
//   mem_write : access is a write (only meaningful with mem_req)
//   iord      : address select, 0 = pc, 1 = alu_out
//   mem_ready : memory completes the current access this cycle
// master = controller side, slave = memory side.
interface mips_multicycle_ctrl_if;
    logic mem_req;
    logic mem_write;
    logic iord;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_write,
        output iord,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_write,
        input  iord,
        output mem_ready
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM. Sequences a shared datapath over several cycles per
// instruction (lw, sw, R-type, beq, addi, j) and counts retired instructions.
// Ports:
//   clk, rst_n          : clock; synchronous active-high reset (rst_n = 1 resets)
//   op_i, funct_i       : instruction register opcode / function fields
//   zero                : alu zero flag, used by beq
//   mem                 : memory handshake (req/write/iord out, ready in)
//   ir_write, pc_write  : instruction register / pc load strobes
//   pc_src              : 00 pc+4, 01 branch target, 10 jump target
//   reg_write, reg_dst, mem_to_reg : register file write controls
//   alusrca, alusrcb, alu_op       : alu operand selects and operation
//   illegal             : one-cycle registered pulse on unsupported op/funct
//   retired             : instructions completed since reset, wraps
module mips_multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [5:0]               op_i,
    input  logic [5:0]               funct_i,
    input  logic                     zero,
    mips_multicycle_ctrl_if.master   mem,
    output logic                     ir_write,
    output logic                     pc_write,
    output logic [1:0]               pc_src,
    output logic                     reg_write,
    output logic                     reg_dst,
    output logic                     mem_to_reg,
    output logic                     alusrca,
    output logic [1:0]               alusrcb,
    output logic [3:0]               alu_op,
    output logic                     illegal,
    output logic [CNT_W-1:0]         retired
);

    localparam logic [3:0] StFetch  = 4'd0;
    localparam logic [3:0] StDecode = 4'd1;
    localparam logic [3:0] StMemAdr = 4'd2;
    localparam logic [3:0] StMemRd  = 4'd3;
    localparam logic [3:0] StMemWb  = 4'd4;
    localparam logic [3:0] StMemWr  = 4'd5;
    localparam logic [3:0] StRtype  = 4'd6;
    localparam logic [3:0] StAluWb  = 4'd7;
    localparam logic [3:0] StBranch = 4'd8;
    localparam logic [3:0] StAddiEx = 4'd9;
    localparam logic [3:0] StAddiWb = 4'd10;
    localparam logic [3:0] StJump   = 4'd11;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;
    localparam logic [3:0] AluNor = 4'b1100;

    logic [3:0]       state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;

    always_comb begin
        state_d       = state_q;
        illegal_d     = 1'b0;
        retire        = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_write = 1'b0;
        mem.iord      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 2'b00;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alusrca       = 1'b0;
        alusrcb       = 2'b00;
        alu_op        = AluAnd;

        case (state_q)
            StFetch: begin
                mem.mem_req = 1'b1;
                alusrcb     = 2'b01;
                alu_op      = AluAdd;
                // IR and pc+4 load only on the cycle the memory delivers.
                if (mem.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                // Branch target is computed speculatively into alu_out.
                alusrcb = 2'b11;
                alu_op  = AluAdd;
                case (op_i)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StRtype;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJump;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                alu_op  = AluAdd;
                state_d = (op_i == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                mem.mem_req = 1'b1;
                mem.iord    = 1'b1;
                if (mem.mem_ready) begin
                    state_d = StMemWb;
                end
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                mem.mem_req   = 1'b1;
                mem.mem_write = 1'b1;
                mem.iord      = 1'b1;
                if (mem.mem_ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StRtype: begin
                alusrca = 1'b1;
                state_d = StAluWb;
                case (funct_i)
                    6'b100000: alu_op = AluAdd;
                    6'b100010: alu_op = AluSub;
                    6'b100100: alu_op = AluAnd;
                    6'b100101: alu_op = AluOr;
                    6'b101010: alu_op = AluSlt;
                    6'b100111: alu_op = AluNor;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = StFetch;
                    end
                endcase
            end
            StAluWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                alusrca  = 1'b1;
                alu_op   = AluSub;
                pc_src   = 2'b01;
                pc_write = zero;
                retire   = 1'b1;
                state_d  = StFetch;
            end
            StAddiEx: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                alu_op  = AluAdd;
                state_d = StAddiWb;
            end
            StAddiWb: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StJump: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                retire   = 1'b1;
                state_d  = StFetch;
            end
            default: state_d = StFetch;
        endcase

        // The reset cycle must not disturb the datapath.
        if (rst_n) begin
            mem.mem_req   = 1'b0;
            mem.mem_write = 1'b0;
            mem.iord      = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_src        = 2'b00;
            reg_write     = 1'b0;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            alusrca       = 1'b0;
            alusrcb       = 2'b00;
            alu_op        = AluAnd;
            retire        = 1'b0;
            illegal_d     = 1'b0;
            state_d       = StFetch;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: per-instruction expected cycle scripts,
// a vector table, random instruction streams and hand-written reset/wait sequences.
module tb_mips_multicycle_ctrl;

    localparam int unsigned W = 4;  // small counter so wrap-around is reached

    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [5:0]   op_i;
    logic [5:0]   funct_i;
    logic         zero;
    logic         ir_write, pc_write, reg_write, reg_dst, mem_to_reg, alusrca, illegal;
    logic [1:0]   pc_src, alusrcb;
    logic [3:0]   alu_op;
    logic [W-1:0] retired;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl #(.CNT_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_i       (op_i),
        .funct_i    (funct_i),
        .zero       (zero),
        .mem        (bus.master),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .alu_op     (alu_op),
        .illegal    (illegal),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    logic [16:0] act;
    assign act = {bus.mem_req, bus.mem_write, bus.iord, ir_write, pc_write, pc_src,
                  reg_write, reg_dst, mem_to_reg, alusrca, alusrcb, alu_op};

    int           errors = 0;
    int           checks = 0;
    logic         m_ill;   // expected illegal this cycle
    logic [W-1:0] m_ret;   // expected retired count this cycle

    function automatic logic [16:0] ov(input logic req, input logic wr, input logic iord,
                                       input logic irw, input logic pcw, input logic [1:0] pcs,
                                       input logic rw, input logic rd, input logic m2r,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [3:0] alu);
        return {req, wr, iord, irw, pcw, pcs, rw, rd, m2r, asa, asb, alu};
    endfunction

    // One clock: apply inputs, compare at negedge, then advance the model.
    task automatic cyc(input string name, input logic [16:0] exp, input logic rdy,
                       input logic zr, input logic ret_now, input logic ill_next);
        bus.mem_ready = rdy;
        zero          = zr;
        @(negedge clk);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s outputs: got %h expected %h", name, act, exp);
        end
        checks++;
        if (illegal !== m_ill) begin
            errors++;
            $display("FAIL %s illegal: got %b expected %b", name, illegal, m_ill);
        end
        checks++;
        if (retired !== m_ret) begin
            errors++;
            $display("FAIL %s retired: got %0d expected %0d", name, retired, m_ret);
        end
        @(posedge clk);
        #1;
        m_ill = ill_next;
        if (ret_now) m_ret = m_ret + 1'b1;
    endtask

    function automatic logic legal_op(input logic [5:0] op);
        case (op)
            6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // R-type function table: returns {legal, alu_op}.
    function automatic logic [4:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: return {1'b1, 4'b0010};
            6'b100010: return {1'b1, 4'b0110};
            6'b100100: return {1'b1, 4'b0000};
            6'b100101: return {1'b1, 4'b0001};
            6'b101010: return {1'b1, 4'b0111};
            6'b100111: return {1'b1, 4'b1100};
            default:   return {1'b0, 4'b0000};
        endcase
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected cycle-by-cycle script of one whole instruction, starting in fetch.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] funct, input logic zr,
                             input int fw, input int mw);
        logic [4:0] fa;
        op_i    = op;
        funct_i = funct;
        for (int i = 0; i < fw; i++)
            cyc("fetch_wait", ov(1,0,0,0,0,2'b00,0,0,0,0,2'b01,ADD), 1'b0, zr, 0, 0);
        cyc("fetch", ov(1,0,0,1,1,2'b00,0,0,0,0,2'b01,ADD), 1'b1, zr, 0, 0);
        cyc("decode", ov(0,0,0,0,0,2'b00,0,0,0,0,2'b11,ADD), rnd(), zr, 0, !legal_op(op));
        case (op)
            6'b100011, 6'b101011: begin
                logic [16:0] acc;
                logic        is_sw;
                is_sw = (op == 6'b101011);
                acc   = ov(1,is_sw,1,0,0,2'b00,0,0,0,0,2'b00,4'b0000);
                cyc("memadr", ov(0,0,0,0,0,2'b00,0,0,0,1,2'b10,ADD), rnd(), zr, 0, 0);
                for (int i = 0; i < mw; i++) cyc("mem_wait", acc, 1'b0, zr, 0, 0);
                cyc("mem_done", acc, 1'b1, zr, is_sw, 0);
                if (!is_sw)
                    cyc("memwb", ov(0,0,0,0,0,2'b00,1,0,1,0,2'b00,4'b0000), rnd(), zr, 1, 0);
            end
            6'b000000: begin
                fa = funct_alu(funct);
                cyc("rtype", ov(0,0,0,0,0,2'b00,0,0,0,1,2'b00,fa[3:0]), rnd(), zr, 0, !fa[4]);
                if (fa[4])
                    cyc("aluwb", ov(0,0,0,0,0,2'b00,1,1,0,0,2'b00,4'b0000), rnd(), zr, 1, 0);
            end
            6'b000100:
                cyc("branch", ov(0,0,0,0,zr,2'b01,0,0,0,1,2'b00,SUB), rnd(), zr, 1, 0);
            6'b001000: begin
                cyc("addiex", ov(0,0,0,0,0,2'b00,0,0,0,1,2'b10,ADD), rnd(), zr, 0, 0);
                cyc("addiwb", ov(0,0,0,0,0,2'b00,1,0,0,0,2'b00,4'b0000), rnd(), zr, 1, 0);
            end
            6'b000010:
                cyc("jump", ov(0,0,0,0,1,2'b10,0,0,0,0,2'b00,4'b0000), rnd(), zr, 1, 0);
            default: ;
        endcase
    endtask

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zr;
        int         ret;  // retired delta
        logic       ill;  // illegal pulse seen right after
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [W-1:0] start;
        tbl[0]  = '{"lw",       6'b100011, 6'b000000, 1'b0, 1, 1'b0};
        tbl[1]  = '{"sw",       6'b101011, 6'b000000, 1'b0, 1, 1'b0};
        tbl[2]  = '{"add",      6'b000000, 6'b100000, 1'b0, 1, 1'b0};
        tbl[3]  = '{"sub",      6'b000000, 6'b100010, 1'b0, 1, 1'b0};
        tbl[4]  = '{"and",      6'b000000, 6'b100100, 1'b0, 1, 1'b0};
        tbl[5]  = '{"or",       6'b000000, 6'b100101, 1'b0, 1, 1'b0};
        tbl[6]  = '{"slt",      6'b000000, 6'b101010, 1'b0, 1, 1'b0};
        tbl[7]  = '{"nor",      6'b000000, 6'b100111, 1'b0, 1, 1'b0};
        tbl[8]  = '{"bad_fn",   6'b000000, 6'b000000, 1'b0, 0, 1'b1};
        tbl[9]  = '{"beq_t",    6'b000100, 6'b000000, 1'b1, 1, 1'b0};
        tbl[10] = '{"beq_nt",   6'b000100, 6'b000000, 1'b0, 1, 1'b0};
        tbl[11] = '{"addi",     6'b001000, 6'b000000, 1'b0, 1, 1'b0};
        tbl[12] = '{"j",        6'b000010, 6'b000000, 1'b0, 1, 1'b0};
        tbl[13] = '{"bad_op",   6'b111111, 6'b000000, 1'b0, 0, 1'b1};

        // Reset held with memory ready: nothing may strobe.
        rst_n         = 1'b1;
        op_i          = 6'b100011;
        funct_i       = 6'b000000;
        zero          = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ill = 1'b0;
        m_ret = '0;
        for (int i = 0; i < 3; i++) cyc("reset", 17'h0, 1'b1, 1'b0, 0, 0);
        rst_n = 1'b0;

        // Fetch waits three cycles, then lw with a memory wait.
        run_instr(6'b100011, 6'b000000, 1'b0, 3, 2);

        // Vector table, no waits.
        foreach (tbl[k]) begin
            start = m_ret;
            run_instr(tbl[k].op, tbl[k].funct, tbl[k].zr, 0, 0);
            checks++;
            if (retired !== W'(start + W'(tbl[k].ret))) begin
                errors++;
                $display("FAIL tbl_%s retired: got %0d expected %0d", tbl[k].name, retired,
                         W'(start + W'(tbl[k].ret)));
            end
            checks++;
            if (illegal !== tbl[k].ill) begin
                errors++;
                $display("FAIL tbl_%s illegal: got %b expected %b", tbl[k].name, illegal,
                         tbl[k].ill);
            end
        end

        // sw stalled in the write, then reset: aborted without retiring.
        op_i    = 6'b101011;
        funct_i = 6'b000000;
        cyc("abort_fetch", ov(1,0,0,1,1,2'b00,0,0,0,0,2'b01,ADD), 1'b1, 1'b0, 0, 0);
        cyc("abort_decode", ov(0,0,0,0,0,2'b00,0,0,0,0,2'b11,ADD), 1'b0, 1'b0, 0, 0);
        cyc("abort_memadr", ov(0,0,0,0,0,2'b00,0,0,0,1,2'b10,ADD), 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 2; i++)
            cyc("abort_wait", ov(1,1,1,0,0,2'b00,0,0,0,0,2'b00,4'b0000), 1'b0, 1'b0, 0, 0);
        rst_n = 1'b1;
        cyc("abort_reset", 17'h0, 1'b1, 1'b0, 0, 0);
        rst_n = 1'b0;
        m_ret = '0;
        // Counter was cleared by that reset; first fetch after release follows.
        run_instr(6'b000010, 6'b000000, 1'b0, 1, 0);

        // Random instruction stream with random waits.
        for (int n = 0; n < 150; n++) begin
            logic [5:0] op, fn;
            int         pick;
            pick = $urandom_range(0, 8);
            fn   = 6'($urandom);
            case (pick)
                0: op = 6'b100011;
                1: op = 6'b101011;
                2, 3: begin
                    op = 6'b000000;
                    if ($urandom_range(0, 4) != 0) begin
                        case ($urandom_range(0, 5))
                            0: fn = 6'b100000;
                            1: fn = 6'b100010;
                            2: fn = 6'b100100;
                            3: fn = 6'b100101;
                            4: fn = 6'b101010;
                            default: fn = 6'b100111;
                        endcase
                    end
                end
                4: op = 6'b000100;
                5: op = 6'b001000;
                6: op = 6'b000010;
                default: begin
                    op = 6'($urandom);
                    while (legal_op(op)) op = 6'($urandom);
                end
            endcase
            run_instr(op, fn, rnd(), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle control FSM that sequences the shared MIPS datapath (pc, instruction/data memory, regfile, sign_extend, alu) over several cycles per instruction.
- Replaces single-cycle decode; one memory port is shared by fetch and load/store through a req/ready handshake.
- Generates all datapath enables, mux selects and the 4-bit alu_op, and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset; one clock; reset is synchronous and active-high (1 = reset)
- op_i  in  6  instr[31:26] from instruction register
- funct_i  in  6  instr[5:0] from instruction register
- zero  in  1  alu zero flag
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  access is a write (valid with mem_req)
- iord  out  1  memory address select: 0 = pc, 1 = alu_out
- ir_write  out  1  load instruction register
- pc_write  out  1  unconditional pc update
- pc_src  out  2  00 = alu_result (pc+4), 01 = alu_out (branch target), 10 = jump target
- reg_write  out  1  regfile write enable
- reg_dst  out  1  write address: 0 = instr[20:16], 1 = instr[15:11]
- mem_to_reg  out  1  write data: 0 = alu_out, 1 = mem data reg
- alusrca  out  1  0 = pc, 1 = rs
- alusrcb  out  2  00 = rt, 01 = const 4, 10 = sign_imm, 11 = sign_imm<<2
- alu_op  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
- illegal  out  1  one-cycle pulse on unsupported opcode/funct
- retired  out  CNT_W  instructions completed since reset

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- Reset (rst_n=1 at edge): state <= FETCH, retired <= 0, illegal <= 0. During the reset cycle all strobes (mem_req, mem_write, ir_write, pc_write, reg_write) are forced 0; selects are 0. Reset mid-instruction aborts it with no retire.
- Outputs not listed below are 0 in every state.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, alu_op=ADD, pc_src=00. If mem_ready: ir_write=1, pc_write=1, go DECODE. Otherwise stay with ir_write=pc_write=0. Waiting is unbounded.
- DECODE: alusrca=0, alusrcb=11, alu_op=ADD (branch target into alu_out). Next state by op_i:
  - 100011 or 101011 -> MEMADR
  - 000000 -> RTYPE
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - anything else -> FETCH, with illegal pulsed for 1 cycle.
- MEMADR: alusrca=1, alusrcb=10, alu_op=ADD. Go MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Stay until mem_ready, then go MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, retire, go FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1. Stay until mem_ready, then retire and go FETCH.
- RTYPE: alusrca=1, alusrcb=00, alu_op from funct_i: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR. Go ALUWB. Any other funct: illegal pulse, go FETCH, no write, no retire.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, retire, go FETCH.
- BRANCH: alusrca=1, alusrcb=00, alu_op=SUB, pc_src=01, pc_write=zero (combinational on zero). Retire, go FETCH.
- ADDIEX: alusrca=1, alusrcb=10, alu_op=ADD, go ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, retire, go FETCH.
- JUMP: pc_src=10, pc_write=1, retire, go FETCH.
- Retire: retired increments by 1 on the edge leaving the retiring state and wraps modulo 2^CNT_W.
- mem_write is never asserted without mem_req. ir_write and pc_write in FETCH are gated by mem_ready in the same cycle (Mealy).
- Cycle counts with mem_ready held 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Test Plan:
- Reset: hold rst_n=1 for 3 cycles with mem_ready=1 -> mem_req=0, pc_write=0, retired=0. First cycle after release: FETCH with mem_req=1, iord=0.
- Fetch wait: mem_ready low for 3 cycles in FETCH -> state stays FETCH, ir_write=0. Ready on cycle 4 -> ir_write=pc_write=1 that cycle, DECODE next.
- lw (op 100011), ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. MEMWB shows reg_write=1, mem_to_reg=1, reg_dst=0. retired goes 0->1.
- R-type op 000000: funct 100010 -> alu_op=0110 in RTYPE, reg_dst=1 in ALUWB. Funct 000000 -> illegal pulse, no reg_write, retired unchanged.
- beq: zero=1 -> pc_write=1 with pc_src=01. zero=0 -> pc_write=0. Retired increments in both cases.
- sw with mem_ready low 2 cycles in MEMWR, then rst_n=1 -> no retire, state FETCH, all strobes 0.
